// File: rtl/cpu_pkg.sv
// Core-wide constants and types used by the register-file write port logic.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic WB_SRC_PIPE = 1'b0;
  localparam logic WB_SRC_MDU  = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] rd;
    logic [XLEN-1:0]      wd;
  } wb_req_t;

  // x0 is hardwired, so it never shows up as a busy register.
  function automatic logic [31:0] rd_onehot(input logic [RF_ADDR_W-1:0] rd);
    logic [31:0] mask;
    mask = 32'(1) << rd;
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of pipeline, MDU and register-file write-port signals around the arbiter.
interface wb_port_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 wb_valid;
  logic [RF_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_wd;
  logic                 mdu_valid;
  logic [RF_ADDR_W-1:0] mdu_rd;
  logic [XLEN-1:0]      mdu_wd;
  logic                 mdu_ready;
  logic                 rf_we;
  logic [RF_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 rf_src;
  logic [31:0]          busy_mask;
  logic                 stall_req;
  logic [CNT_W-1:0]     fifo_count;

  modport master (
    output wb_valid, wb_rd, wb_wd, mdu_valid, mdu_rd, mdu_wd,
    input  mdu_ready, rf_we, rf_waddr, rf_wdata, rf_src, busy_mask, stall_req, fifo_count
  );

  modport slave (
    input  wb_valid, wb_rd, wb_wd, mdu_valid, mdu_rd, mdu_wd,
    output mdu_ready, rf_we, rf_waddr, rf_wdata, rf_src, busy_mask, stall_req, fifo_count
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Small FIFO holding MDU results {rd, wd} until the write port is free.
module wb_result_fifo
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [RF_ADDR_W-1:0]         push_rd,
  input  logic [XLEN-1:0]              push_wd,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [RF_ADDR_W-1:0]         head_rd,
  output logic [XLEN-1:0]              head_wd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [RF_ADDR_W-1:0] rd_mem [DEPTH];
  logic [XLEN-1:0]      wd_mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  // Storage is not reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr] <= push_rd;
      wd_mem[wr_ptr] <= push_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_rd = rd_mem[rd_ptr];
  assign head_wd = wd_mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority) and
// buffered MDU results, with a busy mask and stall request for the hazard unit.
module wb_port_arbiter
  import cpu_pkg::*;
#(
  parameter int XLEN       = cpu_pkg::XLEN,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SW    = $clog2(STARVE_MAX + 1);

  logic                 pipe_req;
  logic                 push;
  logic                 pop;
  logic                 ready;
  logic [CNT_W-1:0]     count;
  logic [RF_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]      head_wd;
  logic [31:0]          busy;
  logic [SW-1:0]        starve_cnt;

  logic                 we;
  logic [RF_ADDR_W-1:0] waddr;
  logic [XLEN-1:0]      wdata;
  logic                 src;

  assign pipe_req = bus.wb_valid && (bus.wb_rd != '0);
  assign ready    = (count != CNT_W'(DEPTH));
  // x0 results are acknowledged but dropped rather than occupying a slot.
  assign push     = bus.mdu_valid && ready && (bus.mdu_rd != '0) && !rst;

  wb_result_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_rd (bus.mdu_rd),
    .push_wd (bus.mdu_wd),
    .pop     (pop),
    .count   (count),
    .head_rd (head_rd),
    .head_wd (head_wd)
  );

  // Pipeline always wins; the FIFO head drains only into otherwise idle slots.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    src   = WB_SRC_PIPE;
    pop   = 1'b0;
    if (!rst) begin
      if (pipe_req) begin
        we    = 1'b1;
        waddr = bus.wb_rd;
        wdata = bus.wb_wd;
      end else if (count != '0) begin
        we    = 1'b1;
        waddr = head_rd;
        wdata = head_wd;
        src   = WB_SRC_MDU;
        pop   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~(pop ? rd_onehot(head_rd) : 32'd0))
            | (push ? rd_onehot(bus.mdu_rd) : 32'd0);
    end
  end

  // Counts consecutive cycles the pipeline held the port while results waited.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if ((count != '0) && pipe_req) begin
      if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  assign bus.mdu_ready  = ready;
  assign bus.rf_we      = we;
  assign bus.rf_waddr   = waddr;
  assign bus.rf_wdata   = wdata;
  assign bus.rf_src     = src;
  assign bus.busy_mask  = busy;
  assign bus.stall_req  = (count == CNT_W'(DEPTH)) || (starve_cnt == SW'(STARVE_MAX));
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
  import cpu_pkg::*;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  typedef struct {
    logic        ready;
    int          count;
    logic        stall;
    logic [31:0] busy;
    logic        we;
  } stat_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        src;
  } wr_t;

  logic clk;
  logic rst;

  wb_port_arbiter_if #(.XLEN(32), .DEPTH(DEPTH)) bus();

  wb_port_arbiter #(
    .XLEN       (32),
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ent_t  model_q[$];
  int    starve_m;
  stat_t stat_q[$];
  wr_t   wr_q[$];
  int    checks;
  int    passes;

  function automatic wb_req_t mk(input logic v, input logic [4:0] rd, input logic [31:0] wd);
    wb_req_t r;
    r.valid = v;
    r.rd    = rd;
    r.wd    = wd;
    return r;
  endfunction

  function automatic bit is_queued(input logic [4:0] rd);
    foreach (model_q[i]) if (model_q[i].rd == rd) return 1'b1;
    return 1'b0;
  endfunction

  // Registers the hazard unit would allow: anything not waiting in the FIFO.
  function automatic logic [4:0] pick_rd();
    logic [4:0] r;
    for (int k = 0; k < 64; k++) begin
      r = 5'($urandom_range(31));
      if (r == 5'd0 || !is_queued(r)) return r;
    end
    return 5'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

  // One clock cycle of stimulus; the model predicts this cycle's outputs, then steps.
  task automatic applyStimulus(input logic r, input wb_req_t p, input wb_req_t m);
    stat_t s;
    int    cnt;
    bit    pipe;
    ent_t  e;
    @(posedge clk);
    #1;
    rst           = r;
    bus.wb_valid  = p.valid;
    bus.wb_rd     = p.rd;
    bus.wb_wd     = p.wd;
    bus.mdu_valid = m.valid;
    bus.mdu_rd    = m.rd;
    bus.mdu_wd    = m.wd;

    cnt     = model_q.size();
    s.ready = (cnt != DEPTH);
    s.count = cnt;
    s.stall = (cnt == DEPTH) || (starve_m == STARVE_MAX);
    s.busy  = '0;
    foreach (model_q[i]) s.busy[model_q[i].rd] = 1'b1;
    s.we    = 1'b0;

    if (r) begin
      model_q.delete();
      starve_m = 0;
    end else begin
      pipe = p.valid && (p.rd != 5'd0);
      if (pipe) begin
        s.we = 1'b1;
        wr_q.push_back('{addr: p.rd, data: p.wd, src: 1'b0});
      end else if (cnt > 0) begin
        e = model_q.pop_front();
        s.we = 1'b1;
        wr_q.push_back('{addr: e.rd, data: e.wd, src: 1'b1});
      end
      if (m.valid && (cnt != DEPTH) && (m.rd != 5'd0))
        model_q.push_back('{rd: m.rd, wd: m.wd});
      if (cnt > 0 && pipe) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
      else starve_m = 0;
    end
    stat_q.push_back(s);
  endtask

  // Monitor: status every cycle, and a write record whenever the DUT writes.
  always @(negedge clk) begin
    stat_t s;
    wr_t   w;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      checkOutput("mdu_ready",  64'(bus.mdu_ready),  64'(s.ready));
      checkOutput("fifo_count", 64'(bus.fifo_count), 64'(s.count));
      checkOutput("stall_req",  64'(bus.stall_req),  64'(s.stall));
      checkOutput("busy_mask",  64'(bus.busy_mask),  64'(s.busy));
      checkOutput("rf_we",      64'(bus.rf_we),      64'(s.we));
      if (bus.rf_we === 1'b1) begin
        if (wr_q.size() == 0) begin
          checkOutput("unexpected_write", 64'(bus.rf_waddr), 64'hFFFF);
        end else begin
          w = wr_q.pop_front();
          checkOutput("rf_waddr", 64'(bus.rf_waddr), 64'(w.addr));
          checkOutput("rf_wdata", 64'(bus.rf_wdata), 64'(w.data));
          checkOutput("rf_src",   64'(bus.rf_src),   64'(w.src));
        end
      end
    end
  end

  initial begin
    wb_req_t none;
    wb_req_t p;
    wb_req_t m;
    checks   = 0;
    passes   = 0;
    starve_m = 0;
    none     = mk(1'b0, 5'd0, 32'd0);
    rst           = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_wd     = '0;
    bus.mdu_valid = 1'b0;
    bus.mdu_rd    = '0;
    bus.mdu_wd    = '0;
    repeat (2) @(posedge clk);

    applyStimulus(1'b1, none, none);
    applyStimulus(1'b0, mk(1'b1, 5'd5, 32'h1234), none);

    applyStimulus(1'b0, none, mk(1'b1, 5'd7, 32'hBEEF));
    applyStimulus(1'b0, none, none);
    applyStimulus(1'b0, none, none);

    applyStimulus(1'b0, mk(1'b1, 5'd9, 32'h11), mk(1'b1, 5'd3, 32'h33));
    applyStimulus(1'b0, mk(1'b1, 5'd9, 32'h12), mk(1'b1, 5'd4, 32'h44));
    applyStimulus(1'b0, mk(1'b1, 5'd9, 32'h13), none);
    applyStimulus(1'b0, none, none);
    applyStimulus(1'b0, none, none);
    applyStimulus(1'b0, none, none);

    applyStimulus(1'b0, none, mk(1'b1, 5'd6, 32'h66));
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, mk(1'b1, 5'd10, 32'(i)), none);
    applyStimulus(1'b0, none, none);
    applyStimulus(1'b0, none, none);

    applyStimulus(1'b0, none, mk(1'b1, 5'd0, 32'hDEAD));
    applyStimulus(1'b0, none, none);
    applyStimulus(1'b0, mk(1'b1, 5'd1, 32'h1), mk(1'b1, 5'd12, 32'hC0));
    applyStimulus(1'b0, mk(1'b1, 5'd0, 32'h2), none);
    applyStimulus(1'b0, none, none);

    applyStimulus(1'b0, mk(1'b1, 5'd2, 32'h2), mk(1'b1, 5'd20, 32'hA0));
    applyStimulus(1'b0, mk(1'b1, 5'd2, 32'h3), mk(1'b1, 5'd21, 32'hA1));
    applyStimulus(1'b1, none, none);
    applyStimulus(1'b0, none, none);
    applyStimulus(1'b0, none, none);

    for (int i = 0; i < 400; i++) begin
      p = mk(($urandom_range(99) < 60), pick_rd(), $urandom());
      m = mk(($urandom_range(99) < 45), pick_rd(), $urandom());
      applyStimulus(($urandom_range(99) == 0), p, m);
    end

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, none, none);
    @(negedge clk);
    #1;
    checkOutput("pending_writes", 64'(wr_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
